decode_regfile: RTL and testbench
=================================

# decode_regfile

Decode/write-back stage of the Y86-64 pipeline: the producer side of the decode-to-execute interface. It decodes the instruction held in the fetch/decode register, and holds the 15-entry 64-bit register file written by write-back. It reads operands with full forwarding from execute, memory and write-back, and presents the complete `d_*` bundle that the execute pipeline register captures on the next clock edge.

## Interface
Parameters:
- `RNONE`, default 4'hF: "no register" ID.
- `RSP`, default 4'h4: stack pointer ID.

Ports:
- `clk`  in  1: sole clock; all state updates on posedge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `D_stat`  in  2: status from the fetch/decode register.
- `D_opcode`  in  8: icode in [7:4], ifun in [3:0].
- `D_rA`, `D_rB`  in  4 each: register specifiers.
- `D_valC`, `D_valP`  in  64 each: constant and next PC.
- `e_dstE`  in  4, `e_valE`  in  64: execute-stage result (already cancelled to RNONE when a cmov is not taken).
- `M_dstE`, `M_dstM`  in  4 each; `M_valE`, `m_valM`  in  64 each: memory-stage results.
- `W_dstE`, `W_dstM`  in  4 each; `W_valE`, `W_valM`  in  64 each: write-back results and register-file write ports.
- `d_stat`  out  2; `d_opcode`  out  8; `d_valA`, `d_valB`, `d_valC`  out  64 each; `d_dstE`, `d_dstM`, `d_srcA`, `d_srcB`  out  4 each: the bundle presented to the execute pipeline register.

## Operation
- `d_stat` = `D_stat`.
- `d_opcode` = `D_opcode`.
- `d_valC` = `D_valC`.
- `d_srcA`:
  - rA for rrmovq/cmovXX (2), rmmovq (4), OPq (6), pushq (A).
  - RSP for popq (B) and ret (9).
  - Otherwise RNONE.
- `d_srcB`:
  - rB for rmmovq, mrmovq (5), OPq.
  - RSP for pushq, popq, call (8), ret.
  - Otherwise RNONE.
- `d_dstE`:
  - rB for cmovXX, irmovq (3), OPq.
  - RSP for pushq, popq, call, ret.
  - Otherwise RNONE.
- `d_dstM`: rA for mrmovq and popq; otherwise RNONE.
- Undefined icodes (C–F), halt and nop: all four register IDs are RNONE.
- `d_valA` (Sel+FwdA), first match wins:
  1. icode is call or jXX (7): `D_valP`.
  2. `d_srcA` == `e_dstE`: `e_valE`.
  3. `d_srcA` == `M_dstM`: `m_valM`.
  4. `d_srcA` == `M_dstE`: `M_valE`.
  5. `d_srcA` == `W_dstM`: `W_valM`.
  6. `d_srcA` == `W_dstE`: `W_valE`.
  7. Otherwise: register file.
- `d_valB` (FwdB): same priority chain without step 1, keyed on `d_srcB`.
- A source of RNONE never matches a forwarding destination and reads 0.
- Register file:
  - 15 × 64-bit registers.
  - On posedge, write `W_valE` to `W_dstE` if it is not RNONE, and `W_valM` to `W_dstM` if it is not RNONE.
  - If both writes target the same register, `W_valM` wins (popq %rsp semantics).
  - Reads are combinational.
- Reset: `rst_n` low clears all 15 registers to 0 immediately, with no clock required. Writes are inhibited while `rst_n` is low.

## Timing
- Decode and forwarding paths are purely combinational. `d_*` is valid in the same cycle that `D_*` and the forwarding inputs are valid, and is captured by the execute register at the next posedge.
- A register-file write becomes visible to the array read one cycle after it is presented on the W ports. In the presenting cycle the W forwarding path supplies the value instead, so a same-cycle read-after-write always returns the new value.
- Outputs during and after reset:
  - All register-file-sourced operands read 0.
  - Passthrough outputs follow their inputs.
  - There are no other output registers, so no additional reset values exist.
- Reset asserted mid-operation discards any pending W write in that cycle.
- Stalls and bubbles are the pipeline control's responsibility; this block has no stall input.

## Structure
- Shared package `y86_pkg`:
  - icode constants `I_HALT`..`I_POPQ`.
  - Register IDs `RSP` and `RNONE`.
  - Stat encodings: `AOK`=0, `HLT`=1, `ADR`=2, `INS`=3.
- Sub-module `regfile15x64`:
  - Async active-low clear.
  - Two write ports with M-priority.
  - Two combinational read ports; returns 0 for RNONE.
- The decode tables and forwarding muxes live in the top level.

## Test plan
- Reset, then W writes 0x11 to reg 3. Next cycle, OPq with rA=3, rB=3 and no forwarding → `d_valA` = `d_valB` = 0x11, `d_dstE`=3, `d_srcA`=3.
- Forwarding priority:
  - srcA=2 with `e_dstE`=2 (0xAA), `M_dstE`=2 (0xBB), `W_dstE`=2 (0xCC) → `d_valA`=0xAA.
  - Remove the e match → 0xBB.
  - Also remove the M match → 0xCC.
- call with `D_valP`=0x40 while `e_dstE`=RSP → `d_valA`=0x40; `d_valB` = `e_valE` via the RSP forward; `d_dstE`=RSP.
- `W_dstE`=`W_dstM`=5 with `W_valE`=1 and `W_valM`=2 at posedge → reg 5 = 2 afterwards. In the same cycle, a reader of reg 5 sees 2.
- Drop `rst_n` asynchronously mid-cycle after regs are loaded → every register reads 0 before the next edge. A W write presented during reset is not committed.
- icode 0xD (invalid) with `D_stat`=INS → all register IDs are RNONE and `d_stat`=3.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the decode/write-back stage.
// Provides icodes, special register IDs and status codes.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RSP   = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        AOK = 2'd0,
        HLT = 2'd1,
        ADR = 2'd2,
        INS = 2'd3
    } stat_t;

endpackage

// File: rtl/decode_regfile_regfile15x64.sv
// 15 x 64-bit register file: two write ports (M wins), two comb reads.
// Ports: clk, rst_n, dst_e/val_e, dst_m/val_m, src_a/src_b -> val_a/val_b.
module regfile15x64 #(
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  dst_e,
    input  logic [63:0] val_e,
    input  logic [3:0]  dst_m,
    input  logic [63:0] val_m,
    input  logic [3:0]  src_a,
    input  logic [3:0]  src_b,
    output logic [63:0] val_a,
    output logic [63:0] val_b
);

    logic [63:0] regs [0:14];

    // M write is issued last so it overrides E on a shared target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (dst_e != RNONE) begin
                regs[dst_e] <= val_e;
            end
            if (dst_m != RNONE) begin
                regs[dst_m] <= val_m;
            end
        end
    end

    assign val_a = (src_a == RNONE) ? '0 : regs[src_a];
    assign val_b = (src_b == RNONE) ? '0 : regs[src_b];

endmodule

// File: rtl/decode_regfile.sv
// Y86-64 decode stage: register IDs, operand forwarding, register file.
// Ports: D_* fetch/decode bundle, e/M/W forward+write inputs, d_* bundle out.
module decode_regfile #(
    parameter logic [3:0] RNONE = 4'hF,
    parameter logic [3:0] RSP   = 4'h4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  D_stat,
    input  logic [7:0]  D_opcode,
    input  logic [3:0]  D_rA,
    input  logic [3:0]  D_rB,
    input  logic [63:0] D_valC,
    input  logic [63:0] D_valP,
    input  logic [3:0]  e_dstE,
    input  logic [63:0] e_valE,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic [63:0] M_valE,
    input  logic [63:0] m_valM,
    input  logic [3:0]  W_dstE,
    input  logic [3:0]  W_dstM,
    input  logic [63:0] W_valE,
    input  logic [63:0] W_valM,
    output logic [1:0]  d_stat,
    output logic [7:0]  d_opcode,
    output logic [63:0] d_valA,
    output logic [63:0] d_valB,
    output logic [63:0] d_valC,
    output logic [3:0]  d_dstE,
    output logic [3:0]  d_dstM,
    output logic [3:0]  d_srcA,
    output logic [3:0]  d_srcB
);

    import y86_pkg::*;

    logic [3:0]  icode;
    logic [63:0] rf_a;
    logic [63:0] rf_b;

    assign icode    = D_opcode[7:4];
    assign d_stat   = D_stat;
    assign d_opcode = D_opcode;
    assign d_valC   = D_valC;

    always_comb begin
        d_srcA = RNONE;
        d_srcB = RNONE;
        d_dstE = RNONE;
        d_dstM = RNONE;
        unique case (icode)
            I_RRMOVQ: begin
                d_srcA = D_rA;
                d_dstE = D_rB;
            end
            I_IRMOVQ: d_dstE = D_rB;
            I_RMMOVQ: begin
                d_srcA = D_rA;
                d_srcB = D_rB;
            end
            I_MRMOVQ: begin
                d_srcB = D_rB;
                d_dstM = D_rA;
            end
            I_OPQ: begin
                d_srcA = D_rA;
                d_srcB = D_rB;
                d_dstE = D_rB;
            end
            I_CALL: begin
                d_srcB = RSP;
                d_dstE = RSP;
            end
            I_RET, I_POPQ: begin
                d_srcA = RSP;
                d_srcB = RSP;
                d_dstE = RSP;
                d_dstM = (icode == I_POPQ) ? D_rA : RNONE;
            end
            I_PUSHQ: begin
                d_srcA = D_rA;
                d_srcB = RSP;
                d_dstE = RSP;
            end
            default: ;
        endcase
    end

    regfile15x64 #(.RNONE(RNONE)) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .dst_e (W_dstE),
        .val_e (W_valE),
        .dst_m (W_dstM),
        .val_m (W_valM),
        .src_a (d_srcA),
        .src_b (d_srcB),
        .val_a (rf_a),
        .val_b (rf_b)
    );

    // An RNONE source must never pick up a forwarded value.
    always_comb begin
        d_valA = rf_a;
        if (icode == I_CALL || icode == I_JXX)
            d_valA = D_valP;
        else if (d_srcA == RNONE)
            d_valA = rf_a;
        else if (d_srcA == e_dstE)
            d_valA = e_valE;
        else if (d_srcA == M_dstM)
            d_valA = m_valM;
        else if (d_srcA == M_dstE)
            d_valA = M_valE;
        else if (d_srcA == W_dstM)
            d_valA = W_valM;
        else if (d_srcA == W_dstE)
            d_valA = W_valE;
    end

    always_comb begin
        d_valB = rf_b;
        if (d_srcB == RNONE)
            d_valB = rf_b;
        else if (d_srcB == e_dstE)
            d_valB = e_valE;
        else if (d_srcB == M_dstM)
            d_valB = m_valM;
        else if (d_srcB == M_dstE)
            d_valB = M_valE;
        else if (d_srcB == W_dstM)
            d_valB = W_valM;
        else if (d_srcB == W_dstE)
            d_valB = W_valE;
    end

endmodule

// File: tb/tb_decode_regfile.sv
// Directed self-checking bench for decode_regfile.
// Drives D/e/M/W inputs between edges and checks the d_* bundle.
module tb_decode_regfile;

    localparam logic [3:0] NONE = 4'hF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  D_stat;
    logic [7:0]  D_opcode;
    logic [3:0]  D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic [3:0]  e_dstE;
    logic [63:0] e_valE;
    logic [3:0]  M_dstE, M_dstM;
    logic [63:0] M_valE, m_valM;
    logic [3:0]  W_dstE, W_dstM;
    logic [63:0] W_valE, W_valM;
    logic [1:0]  d_stat;
    logic [7:0]  d_opcode;
    logic [63:0] d_valA, d_valB, d_valC;
    logic [3:0]  d_dstE, d_dstM, d_srcA, d_srcB;

    int n_cmp = 0;
    int n_bad = 0;

    decode_regfile dut (
        .clk(clk), .rst_n(rst_n),
        .D_stat(D_stat), .D_opcode(D_opcode),
        .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstE(M_dstE), .M_dstM(M_dstM),
        .M_valE(M_valE), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM),
        .W_valE(W_valE), .W_valM(W_valM),
        .d_stat(d_stat), .d_opcode(d_opcode),
        .d_valA(d_valA), .d_valB(d_valB), .d_valC(d_valC),
        .d_dstE(d_dstE), .d_dstM(d_dstM),
        .d_srcA(d_srcA), .d_srcB(d_srcB)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_fwd();
        e_dstE = NONE; e_valE = '0;
        M_dstE = NONE; M_dstM = NONE;
        M_valE = '0;   m_valM = '0;
        W_dstE = NONE; W_dstM = NONE;
        W_valE = '0;   W_valM = '0;
    endtask

    task automatic instr(input logic [7:0] op, input logic [3:0] ra,
                         input logic [3:0] rb);
        D_opcode = op; D_rA = ra; D_rB = rb;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        D_stat = 2'd0; D_valC = 64'h1234; D_valP = '0;
        instr(8'h10, NONE, NONE);
        clr_fwd();
        #2 rst_n = 1'b0;
        instr(8'h60, 4'd3, 4'd3);
        #1;
        chk("rst_valA", d_valA, 64'h0);
        chk("rst_valB", d_valB, 64'h0);
        chk("rst_valC", d_valC, 64'h1234);
        step();
        rst_n = 1'b1;

        // write reg3 while a reader sees it through W forward
        W_dstE = 4'd3; W_valE = 64'h11;
        #1;
        chk("raw_fwd", d_valA, 64'h11);
        step();
        clr_fwd();
        #1;
        chk("rf_valA", d_valA, 64'h11);
        chk("rf_valB", d_valB, 64'h11);
        chk("opq_dstE", {60'd0, d_dstE}, 64'd3);
        chk("opq_srcA", {60'd0, d_srcA}, 64'd3);
        chk("opq_dstM", {60'd0, d_dstM}, {60'd0, NONE});

        // forwarding priority on srcA=2
        instr(8'h61, 4'd2, NONE);
        e_dstE = 4'd2; e_valE = 64'hAA;
        M_dstE = 4'd2; M_valE = 64'hBB;
        W_dstE = 4'd2; W_valE = 64'hCC;
        M_dstM = 4'd2; m_valM = 64'hDD;
        #1;
        chk("fwd_e", d_valA, 64'hAA);
        e_dstE = NONE;
        #1;
        chk("fwd_mM", d_valA, 64'hDD);
        M_dstM = NONE;
        #1;
        chk("fwd_mE", d_valA, 64'hBB);
        M_dstE = NONE;
        #1;
        chk("fwd_w", d_valA, 64'hCC);
        chk("srcB_none", d_valB, 64'h0);
        step();
        clr_fwd();

        // call: valA = valP, valB forwarded from e on RSP
        instr(8'h80, NONE, NONE);
        D_valP = 64'h40;
        e_dstE = 4'h4; e_valE = 64'h1000;
        #1;
        chk("call_valA", d_valA, 64'h40);
        chk("call_valB", d_valB, 64'h1000);
        chk("call_dstE", {60'd0, d_dstE}, 64'd4);
        chk("call_srcA", {60'd0, d_srcA}, {60'd0, NONE});
        clr_fwd();
        instr(8'h73, NONE, NONE);
        D_valP = 64'h88;
        #1;
        chk("jxx_valA", d_valA, 64'h88);

        // dual write to reg5, M port must win
        instr(8'h60, 4'd5, 4'd5);
        W_dstE = 4'd5; W_valE = 64'h1;
        W_dstM = 4'd5; W_valM = 64'h2;
        #1;
        chk("dual_fwd", d_valA, 64'h2);
        step();
        clr_fwd();
        #1;
        chk("dual_rf", d_valA, 64'h2);

        // decode tables
        instr(8'hB0, 4'd7, NONE);
        #1;
        chk("pop_srcA", {60'd0, d_srcA}, 64'd4);
        chk("pop_srcB", {60'd0, d_srcB}, 64'd4);
        chk("pop_dstE", {60'd0, d_dstE}, 64'd4);
        chk("pop_dstM", {60'd0, d_dstM}, 64'd7);
        instr(8'h50, 4'd1, 4'd2);
        #1;
        chk("mr_srcA", {60'd0, d_srcA}, {60'd0, NONE});
        chk("mr_srcB", {60'd0, d_srcB}, 64'd2);
        chk("mr_dstM", {60'd0, d_dstM}, 64'd1);
        chk("mr_dstE", {60'd0, d_dstE}, {60'd0, NONE});
        chk("mr_valB", d_valB, 64'hCC);
        instr(8'h22, 4'd3, 4'd6);
        #1;
        chk("cmov_srcA", {60'd0, d_srcA}, 64'd3);
        chk("cmov_dstE", {60'd0, d_dstE}, 64'd6);
        chk("cmov_srcB", {60'd0, d_srcB}, {60'd0, NONE});
        instr(8'hA0, 4'd5, NONE);
        #1;
        chk("push_valA", d_valA, 64'h2);
        chk("push_srcB", {60'd0, d_srcB}, 64'd4);
        instr(8'h30, NONE, 4'd6);
        e_dstE = NONE; e_valE = 64'h99;
        #1;
        chk("irm_valA", d_valA, 64'h0);
        chk("irm_valB", d_valB, 64'h0);
        chk("irm_dstE", {60'd0, d_dstE}, 64'd6);
        clr_fwd();

        // async reset mid-cycle
        step();
        #2;
        instr(8'h60, 4'd3, 4'd5);
        #1;
        chk("pre_rst_A", d_valA, 64'h11);
        chk("pre_rst_B", d_valB, 64'h2);
        rst_n = 1'b0;
        #1;
        chk("arst_A", d_valA, 64'h0);
        chk("arst_B", d_valB, 64'h0);
        W_dstE = 4'd3; W_valE = 64'h77;
        step();
        clr_fwd();
        #1;
        chk("rst_nowr", d_valA, 64'h0);
        rst_n = 1'b1;
        #1;
        chk("post_rst", d_valA, 64'h0);

        // invalid icode
        instr(8'hD0, 4'd1, 4'd2);
        D_stat = 2'd3;
        #1;
        chk("inv_stat", {62'd0, d_stat}, 64'd3);
        chk("inv_srcA", {60'd0, d_srcA}, {60'd0, NONE});
        chk("inv_srcB", {60'd0, d_srcB}, {60'd0, NONE});
        chk("inv_dstE", {60'd0, d_dstE}, {60'd0, NONE});
        chk("inv_dstM", {60'd0, d_dstM}, {60'd0, NONE});
        chk("inv_op", {56'd0, d_opcode}, 64'hD0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
